mem_arbiter: RTL and testbench

Shares the single read/write port of the ideal memory between the CPU instruction-fetch requester and the data load/store requester. It accepts one request at a time over valid/ready handshakes. It inserts a programmable access latency to emulate slow memory, drives the memory's word-addressed port for exactly one cycle, and returns the result over a valid/ready response channel. It sits between the MIPS core and the ideal memory in the evaluation top level.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_rr.sv | 20 ++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encodings and requester source constants for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker; on a tie the requester not served last wins
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // grant[0] is the fetch port, grant[1] the load/store port
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (last == SRC_DATA) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the ideal memory port between fetch and load/store requesters,
// with a programmable wait before the single-cycle memory access
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req_valid,
  output logic                  inst_req_ready,
  input  logic [31:0]           inst_addr,
  output logic                  inst_rvalid,
  input  logic                  inst_rready,
  output logic [31:0]           inst_rdata,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic                  data_wen,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_wdata,
  input  logic [3:0]            data_wstrb,
  output logic                  data_rvalid,
  input  logic                  data_rready,
  output logic [31:0]           data_rdata,
  output logic [ADDR_WIDTH-3:0] mem_waddr,
  output logic [ADDR_WIDTH-3:0] mem_raddr,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata
);

  localparam int         WW      = ADDR_WIDTH - 2;
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          src_q, src_d;
  logic          wen_q, wen_d;
  logic [WW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic [31:0]   resp_word;
  logic [1:0]    grant;
  logic          addr_unused;

  // memory is word addressed; byte offset and bits above the memory size are dropped
  assign addr_unused = ^{inst_addr[31:ADDR_WIDTH], inst_addr[1:0],
                         data_addr[31:ADDR_WIDTH], data_addr[1:0]};

  mem_arb_rr u_rr (
    .valid ({data_req_valid, inst_req_valid}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    src_d        = src_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    resp_word    = '0;

    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
    inst_rvalid    = 1'b0;
    data_rvalid    = 1'b0;
    mem_rden       = 1'b0;
    mem_wren       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // resetn gating keeps ready low while reset is held, since state already reads IDLE
        inst_req_ready = grant[0] & resetn;
        data_req_ready = grant[1] & resetn;
        if (grant[1]) begin
          src_d   = SRC_DATA;
          wen_d   = data_wen;
          addr_d  = data_addr[ADDR_WIDTH-1:2];
          wdata_d = data_wdata;
          wstrb_d = data_wstrb;
        end else if (grant[0]) begin
          src_d  = SRC_INST;
          wen_d  = 1'b0;
          addr_d = inst_addr[ADDR_WIDTH-1:2];
        end
        if (|grant) begin
          last_d  = src_d;
          cnt_d   = LAT_CNT;
          state_d = (LAT_CNT == 4'd0) ? ACCESS : WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        mem_rden  = ~wen_q;
        mem_wren  = wen_q;
        resp_word = wen_q ? 32'd0 : mem_rdata;
        if (src_q == SRC_INST) begin
          inst_rdata_d = resp_word;
        end else begin
          data_rdata_d = resp_word;
        end
        state_d = RESP;
      end

      RESP: begin
        if (src_q == SRC_INST) begin
          inst_rvalid = 1'b1;
          if (inst_rready) state_d = IDLE;
        end else begin
          data_rvalid = 1'b1;
          if (data_rready) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= SRC_DATA;
      src_q        <= SRC_INST;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      src_q        <= src_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // address and data lines hold the last accepted request; only the enables pulse
  assign mem_waddr  = addr_q;
  assign mem_raddr  = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assert property (@(posedge clk) disable iff (!resetn) !(mem_rden && mem_wren));
  assert property (@(posedge clk) disable iff (!resetn) !(inst_req_ready && data_req_ready));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int AW  = 14;
  localparam int WW  = AW - 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          inst_req_valid, inst_req_ready, inst_rvalid, inst_rready;
  logic [31:0]   inst_addr, inst_rdata;
  logic          data_req_valid, data_req_ready, data_wen, data_rvalid, data_rready;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic [3:0]    data_wstrb;
  logic [WW-1:0] mem_waddr, mem_raddr;
  logic          mem_wren, mem_rden;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  logic          z_inst_req_valid, z_inst_req_ready, z_inst_rvalid, z_inst_rready;
  logic [31:0]   z_inst_addr, z_inst_rdata;
  logic          z_data_req_valid, z_data_req_ready, z_data_wen, z_data_rvalid, z_data_rready;
  logic [31:0]   z_data_addr, z_data_wdata, z_data_rdata;
  logic [3:0]    z_data_wstrb;
  logic [WW-1:0] z_mem_waddr, z_mem_raddr;
  logic          z_mem_wren, z_mem_rden;
  logic [31:0]   z_mem_wdata, z_mem_rdata;
  logic [3:0]    z_mem_wstrb;

  mem_arbiter #(.ADDR_WIDTH(AW), .LAT(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
    .inst_rvalid(inst_rvalid), .inst_rready(inst_rready), .inst_rdata(inst_rdata),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_rvalid(data_rvalid), .data_rready(data_rready), .data_rdata(data_rdata),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .LAT(0)) dut_lat0 (
    .clk(clk), .resetn(resetn),
    .inst_req_valid(z_inst_req_valid), .inst_req_ready(z_inst_req_ready), .inst_addr(z_inst_addr),
    .inst_rvalid(z_inst_rvalid), .inst_rready(z_inst_rready), .inst_rdata(z_inst_rdata),
    .data_req_valid(z_data_req_valid), .data_req_ready(z_data_req_ready), .data_wen(z_data_wen),
    .data_addr(z_data_addr), .data_wdata(z_data_wdata), .data_wstrb(z_data_wstrb),
    .data_rvalid(z_data_rvalid), .data_rready(z_data_rready), .data_rdata(z_data_rdata),
    .mem_waddr(z_mem_waddr), .mem_raddr(z_mem_raddr), .mem_wren(z_mem_wren), .mem_rden(z_mem_rden),
    .mem_wdata(z_mem_wdata), .mem_wstrb(z_mem_wstrb), .mem_rdata(z_mem_rdata)
  );

  // environment memory behind the main instance, plus a backdoor port for preloading
  logic [31:0] mem [0:(1<<WW)-1];
  logic        bd_we = 1'b0;
  logic [WW-1:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_wren) mem[mem_waddr] <= apply_strb(mem[mem_waddr], mem_wdata, mem_wstrb);
    else if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign mem_rdata   = mem[mem_raddr];
  assign z_mem_rdata = {20'hABCDE, z_mem_raddr};

  // reference model: shadow memory contents and the last served requester (0 fetch, 1 data)
  logic [31:0] ref_mem [0:15];
  int m_last;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return $urandom & 32'hFFFF_C03F;
  endfunction

  task automatic bd_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = WW'(a); bd_data = v;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic check_reset_values();
    check_eq("rst inst_req_ready", inst_req_ready, 0);
    check_eq("rst data_req_ready", data_req_ready, 0);
    check_eq("rst inst_rvalid", inst_rvalid, 0);
    check_eq("rst data_rvalid", data_rvalid, 0);
    check_eq("rst inst_rdata", inst_rdata, 0);
    check_eq("rst data_rdata", data_rdata, 0);
    check_eq("rst mem_wren", mem_wren, 0);
    check_eq("rst mem_rden", mem_rden, 0);
    check_eq("rst mem_waddr", mem_waddr, 0);
    check_eq("rst mem_raddr", mem_raddr, 0);
    check_eq("rst mem_wdata", mem_wdata, 0);
    check_eq("rst mem_wstrb", mem_wstrb, 0);
  endtask

  // called at a negedge with the DUT idle; returns at the negedge after the response is consumed
  task automatic do_txn(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                        input bit wen, input logic [31:0] wd, input logic [3:0] ws, input int hold);
    int src;
    bit is_wr;
    logic [11:0] widx;
    logic [31:0] exp_rd;
    inst_req_valid = iv; inst_addr = ia;
    data_req_valid = dv; data_addr = da; data_wen = wen; data_wdata = wd; data_wstrb = ws;
    #1;
    if (iv && dv) src = (m_last == 1) ? 0 : 1;
    else src = dv ? 1 : 0;
    check_eq("grant inst_req_ready", inst_req_ready, src == 0);
    check_eq("grant data_req_ready", data_req_ready, src == 1);
    m_last = src;
    is_wr  = (src == 1) && wen;
    widx   = (src == 1) ? da[13:2] : ia[13:2];
    if (is_wr) begin
      exp_rd = 32'd0;
      ref_mem[widx[3:0]] = apply_strb(ref_mem[widx[3:0]], wd, ws);
    end else begin
      exp_rd = ref_mem[widx[3:0]];
    end
    @(posedge clk);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      inst_req_valid = 1'($urandom); data_req_valid = 1'($urandom);
      inst_addr = $urandom; data_addr = $urandom; data_wen = 1'($urandom);
      data_wdata = $urandom; data_wstrb = 4'($urandom);
      #1;
      check_eq("busy inst_req_ready", inst_req_ready, 0);
      check_eq("busy data_req_ready", data_req_ready, 0);
      check_eq("mem_rden timing", mem_rden, (c == LAT + 1) && !is_wr);
      check_eq("mem_wren timing", mem_wren, (c == LAT + 1) && is_wr);
      if (c == LAT + 1) begin
        if (is_wr) begin
          check_eq("mem_waddr", mem_waddr, widx);
          check_eq("mem_wdata", mem_wdata, wd);
          check_eq("mem_wstrb", mem_wstrb, ws);
        end else begin
          check_eq("mem_raddr", mem_raddr, widx);
        end
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      inst_rready = 1'b0; data_rready = 1'b0;
      #1;
      check_eq("resp inst_rvalid", inst_rvalid, src == 0);
      check_eq("resp data_rvalid", data_rvalid, src == 1);
      check_eq("resp rdata", (src == 0) ? inst_rdata : data_rdata, exp_rd);
      check_eq("resp no accept", inst_req_ready | data_req_ready, 0);
      if (h == hold) begin
        if (src == 0) begin inst_rready = 1'b1; data_rready = 1'($urandom); end
        else begin data_rready = 1'b1; inst_rready = 1'($urandom); end
      end
    end
    @(negedge clk);
    inst_rready = 1'b0; data_rready = 1'b0;
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    #1;
    check_eq("idle rvalid", {30'd0, inst_rvalid, data_rvalid}, 0);
  endtask

  initial begin
    logic [31:0] old20;
    inst_req_valid = 0; inst_addr = 0; inst_rready = 0;
    data_req_valid = 0; data_wen = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0; data_rready = 0;
    z_inst_req_valid = 0; z_inst_addr = 0; z_inst_rready = 0;
    z_data_req_valid = 0; z_data_wen = 0; z_data_addr = 0; z_data_wdata = 0; z_data_wstrb = 0;
    z_data_rready = 0;
    m_last = 1;
    resetn = 1'b0;
    for (int i = 0; i < 16; i++) bd_write(4'(i), $urandom);
    @(negedge clk);
    inst_req_valid = 1; data_req_valid = 1;
    #1;
    check_reset_values();
    inst_req_valid = 0; data_req_valid = 0;
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 4; k++)
      do_txn(1, 1, rnd_addr(), rnd_addr(), 1'($urandom), $urandom, 4'($urandom), 0);

    bd_write(4'd4, 32'hDEADBEEF);
    do_txn(1, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 4'h0, 0);
    check_eq("inst read word4", ref_mem[4], 32'hDEADBEEF);

    old20 = ref_mem[8];
    do_txn(0, 1, 32'h0, 32'h0000_0020, 1, 32'h11223344, 4'b0011, 0);
    do_txn(0, 1, 32'h0, 32'h0000_0020, 0, 32'h0, 4'h0, 0);
    check_eq("store merge word8", mem[8], {old20[31:16], 16'h3344});

    do_txn(1, 1, rnd_addr(), rnd_addr(), 0, $urandom, 4'hF, 5);
    do_txn(1, 0, rnd_addr(), rnd_addr(), 0, 0, 4'h0, 0);

    // reset pulsed while a store waits: the store must never reach memory
    @(negedge clk);
    inst_req_valid = 0; data_req_valid = 1; data_wen = 1;
    data_addr = 32'h0000_0030; data_wdata = ~ref_mem[12]; data_wstrb = 4'hF;
    #1;
    check_eq("rst-test accept", data_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0; inst_req_valid = 1; data_req_valid = 1;
    #1;
    check_reset_values();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst-test no wren", mem_wren, 0);
    end
    resetn = 1'b1; inst_req_valid = 0; data_req_valid = 0;
    m_last = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post-rst no wren", mem_wren, 0);
    end
    check_eq("rst-test mem unchanged", mem[12], ref_mem[12]);

    for (int k = 0; k < 60; k++) begin
      bit iv, dv;
      iv = 1'($urandom);
      dv = 1'($urandom);
      if (!iv && !dv) dv = 1'b1;
      do_txn(iv, dv, rnd_addr(), rnd_addr(), 1'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 16; i++) check_eq("final mem", mem[i], ref_mem[i]);

    // zero-latency instance: access in the cycle after accept, response one cycle later
    @(negedge clk);
    z_data_req_valid = 1; z_data_wen = 0; z_data_addr = 32'hF000_0044;
    #1;
    check_eq("lat0 ready", z_data_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    z_data_req_valid = 0;
    #1;
    check_eq("lat0 rden", z_mem_rden, 1);
    check_eq("lat0 raddr", z_mem_raddr, 12'h011);
    check_eq("lat0 early rvalid", z_data_rvalid, 0);
    @(negedge clk);
    #1;
    check_eq("lat0 rvalid", z_data_rvalid, 1);
    check_eq("lat0 rdata", z_data_rdata, 32'hABCDE011);
    check_eq("lat0 inst rvalid", z_inst_rvalid, 0);
    z_data_rready = 1;
    @(negedge clk);
    #1;
    check_eq("lat0 done", z_data_rvalid, 0);
    z_data_rready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
